// File: rtl/ntt_r16_stage_scheduler_if.sv
// Handshake bundle between the NTT top-level control, the stage scheduler and
// the index delay pipeline.
interface ntt_r16_stage_scheduler_if #(
    parameter int GRP_W = 8,
    parameter int STG_W = 2
);
    logic             start;
    logic             stall;
    logic             retire_valid;
    logic             issue_valid;
    logic [GRP_W-1:0] grp_idx;
    logic [STG_W-1:0] stage_idx;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stall, retire_valid,
        input  issue_valid, grp_idx, stage_idx, busy, done, err
    );

    modport slave (
        input  start, stall, retire_valid,
        output issue_valid, grp_idx, stage_idx, busy, done, err
    );
endinterface

// File: rtl/ntt_r16_stage_scheduler.sv
// Radix-16 NTT stage sequencer: issues one group per cycle, then waits for the
// index delay pipeline to drain completely before the next stage starts.
module ntt_r16_stage_scheduler #(
    parameter int STAGES   = 3,
    parameter int GROUPS   = 256,
    parameter int PIPE_LAT = 12,
    parameter int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    parameter int STG_W    = (STAGES > 1) ? $clog2(STAGES) : 1,
    parameter int CNT_W    = $clog2(PIPE_LAT + 2)
) (
    input logic clk,
    input logic rst_n,
    ntt_r16_stage_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(GROUPS - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(STAGES - 1);
    localparam logic [CNT_W:0]   LAT_LIMIT = (CNT_W + 1)'(PIPE_LAT);
    localparam logic [CNT_W:0]   CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    state_t           state, state_nxt;
    logic [GRP_W-1:0] grp, grp_nxt;
    logic [STG_W-1:0] stage, stage_nxt;
    logic [CNT_W-1:0] inflight, inflight_d;
    logic [CNT_W:0]   inflight_next;
    logic             err, err_nxt;
    logic             issue;
    logic             underflow;
    logic             overflow;

    assign issue = (state == ISSUE) && !bus.stall;

    // One extra bit of headroom so an overflow is visible before it is clamped.
    always_comb begin
        inflight_next = {1'b0, inflight} + {{CNT_W{1'b0}}, issue};
        if (bus.retire_valid && (inflight_next != '0)) begin
            inflight_next = inflight_next - (CNT_W + 1)'(1);
        end
        underflow  = bus.retire_valid && (inflight == '0);
        overflow   = inflight_next > LAT_LIMIT;
        inflight_d = (inflight_next > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                               : inflight_next[CNT_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        grp_nxt   = grp;
        stage_nxt = stage;
        err_nxt   = err | underflow | overflow;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ISSUE;
                    grp_nxt   = '0;
                    stage_nxt = '0;
                    err_nxt   = underflow | overflow;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (grp == GRP_LAST) begin
                        state_nxt = DRAIN;
                    end else begin
                        grp_nxt = grp + GRP_W'(1);
                    end
                end
            end
            DRAIN: begin
                // The next stage reads what this one wrote, so wait for every retire.
                if (inflight_next == '0) begin
                    if (stage == STG_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        stage_nxt = stage + STG_W'(1);
                        grp_nxt   = '0;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grp      <= '0;
            stage    <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            grp      <= grp_nxt;
            stage    <= stage_nxt;
            inflight <= inflight_d;
            err      <= err_nxt;
        end
    end

    assign bus.issue_valid = issue;
    assign bus.grp_idx     = grp;
    assign bus.stage_idx   = stage;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.err         = err;
endmodule

// File: tb/tb_ntt_r16_stage_scheduler.sv
// Directed bench for the NTT stage scheduler: default configuration plus a
// single-group, single-stage instance; the delay pipeline is modelled here.
module tb_ntt_r16_stage_scheduler;
    logic clk;
    logic rst_n;
    logic spur;
    logic [11:0] pipe;
    logic [11:0] pipe_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int scen        = 0;
    int seen_scen   = 0;
    int exp_grp     = 0;
    int exp_stage   = 0;
    int issue_count = 0;
    int done_count  = 0;
    int done_cyc    = 0;
    int first_issue [3];

    ntt_r16_stage_scheduler_if #(.GRP_W(8), .STG_W(2)) ifc ();
    ntt_r16_stage_scheduler_if #(.GRP_W(1), .STG_W(1)) ifs ();

    ntt_r16_stage_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    ntt_r16_stage_scheduler #(.STAGES(1), .GROUPS(1), .PIPE_LAT(12)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Delay pipelines: an issue in cycle c comes back as a retire in cycle c+12.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe   <= '0;
            pipe_s <= '0;
        end else begin
            pipe   <= {pipe[10:0], ifc.issue_valid};
            pipe_s <= {pipe_s[10:0], ifs.issue_valid};
        end
    end

    assign ifc.retire_valid = pipe[11] | spur;
    assign ifs.retire_valid = pipe_s[11];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sl, input logic sp);
        @(posedge clk);
        #1;
        ifc.start = st;
        ifc.stall = sl;
        spur      = sp;
        @(negedge clk);
        #1;
    endtask

    // Reference sequence of group/stage indices, restarted whenever a new scenario begins.
    always @(negedge clk) begin
        if (seen_scen != scen) begin
            seen_scen   = scen;
            exp_grp     = 0;
            exp_stage   = 0;
            issue_count = 0;
        end
        if (rst_n && ifc.issue_valid) begin
            if (exp_grp == 0 && exp_stage < 3) first_issue[exp_stage] = cyc;
            checkOutput("issue_grp", 32'(ifc.grp_idx), exp_grp);
            checkOutput("issue_stage", 32'(ifc.stage_idx), exp_stage);
            issue_count++;
            if (exp_grp == 255) begin
                exp_grp = 0;
                exp_stage++;
            end else begin
                exp_grp++;
            end
        end
        if (ifc.done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic run_transform(input int stall_from, input int stall_len,
                                 input bit poke_start, input int exp_len);
        int   d0;
        bit   busy_dropped;
        logic sl;
        logic st;
        scen++;
        d0 = done_count;
        busy_dropped = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        for (int k = 1; k <= exp_len + 20 && done_count == d0; k++) begin
            sl = (k >= stall_from) && (k < stall_from + stall_len);
            st = poke_start && (k == 50 || k == 262);
            applyStimulus(st, sl, 1'b0);
            if (k == 1) begin
                checkOutput("first_issue_valid", 32'(ifc.issue_valid), 1);
                checkOutput("busy_after_start", 32'(ifc.busy), 1);
                checkOutput("err_after_start", 32'(ifc.err), 0);
            end
            if (sl) begin
                checkOutput("stall_issue_valid", 32'(ifc.issue_valid), 0);
                checkOutput("stall_grp_hold", 32'(ifc.grp_idx), 100);
            end
            if (k == 260) begin
                checkOutput("drain_no_issue", 32'(ifc.issue_valid), 0);
                checkOutput("drain_grp", 32'(ifc.grp_idx), 255);
            end
            if (!ifc.busy && done_count == d0) busy_dropped = 1'b1;
        end
        checkOutput("done_latency", done_cyc - t0, exp_len);
        checkOutput("issue_count", issue_count, 768);
        checkOutput("stage1_start", first_issue[1] - t0, 269);
        checkOutput("stage2_start", first_issue[2] - t0, 537 + stall_len);
        checkOutput("busy_held", 32'(busy_dropped), 0);
        checkOutput("err_clean_run", 32'(ifc.err), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("busy_after_done", 32'(ifc.busy), 0);
        checkOutput("done_one_cycle", 32'(ifc.done), 0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("done_pulses", done_count - d0, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        spur       = 1'b0;
        ifc.start  = 1'b0;
        ifc.stall  = 1'b0;
        ifs.start  = 1'b0;
        ifs.stall  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_issue_valid", 32'(ifc.issue_valid), 0);
        checkOutput("rst_grp_idx", 32'(ifc.grp_idx), 0);
        checkOutput("rst_stage_idx", 32'(ifc.stage_idx), 0);
        checkOutput("rst_busy", 32'(ifc.busy), 0);
        checkOutput("rst_done", 32'(ifc.done), 0);
        checkOutput("rst_err", 32'(ifc.err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] clean transform");
        run_transform(0, 0, 1'b0, 805);

        $display("[TB] five stall cycles at stage 1 group 100");
        run_transform(369, 5, 1'b0, 810);

        $display("[TB] start pulses during issue and drain");
        run_transform(0, 0, 1'b1, 805);

        $display("[TB] spurious retire in idle");
        scen++;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("spur_err", 32'(ifc.err), 1);
        checkOutput("spur_inflight", 32'(dut.inflight), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("err_cleared_by_start", 32'(ifc.err), 0);
        for (int k = 2; k <= 309; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_point_grp", 32'(ifc.grp_idx), 40);
        checkOutput("abort_point_stage", 32'(ifc.stage_idx), 1);

        $display("[TB] asynchronous reset mid-transform");
        rst_n = 1'b0;
        #1;
        checkOutput("async_issue_valid", 32'(ifc.issue_valid), 0);
        checkOutput("async_grp_idx", 32'(ifc.grp_idx), 0);
        checkOutput("async_stage_idx", 32'(ifc.stage_idx), 0);
        checkOutput("async_busy", 32'(ifc.busy), 0);
        checkOutput("async_done", 32'(ifc.done), 0);
        checkOutput("async_err", 32'(ifc.err), 0);
        checkOutput("async_inflight", 32'(dut.inflight), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        run_transform(0, 0, 1'b0, 805);

        $display("[TB] single group, single stage instance");
        @(posedge clk);
        #1 ifs.start = 1'b1;
        @(negedge clk);
        #1 t0 = cyc;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1 ifs.start = 1'b0;
            @(negedge clk);
            #1;
            checkOutput("small_issue", 32'(ifs.issue_valid), 32'(k == 1));
            checkOutput("small_retire", 32'(ifs.retire_valid), 32'(k == 13));
            checkOutput("small_done", 32'(ifs.done), 32'(k == 14));
            checkOutput("small_busy", 32'(ifs.busy), 32'(k <= 14));
            checkOutput("small_err", 32'(ifs.err), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
